// File: rtl/oram_fetch_arbiter_if.sv
// Bundles the core fetch port, Wishbone slave port and OpenRAM macro pins of the fetch arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the core, the Wishbone master and the macro.
interface oram_fetch_arbiter_if #(
   parameter int ADDR_W = 9
);
   logic              rom_req;
   logic [ADDR_W+1:0] rom_addr;
   logic              rom_valid;
   logic [7:0]        rom_data;

   logic              wbs_cyc_i;
   logic              wbs_stb_i;
   logic              wbs_we_i;
   logic [3:0]        wbs_sel_i;
   logic [31:0]       wbs_adr_i;
   logic [31:0]       wbs_dat_i;
   logic [31:0]       wbs_dat_o;
   logic              wbs_ack_o;

   logic              sram_csb;
   logic              sram_web;
   logic [3:0]        sram_wmask;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_din;
   logic [31:0]       sram_dout;

   modport slave (
      input  rom_req, rom_addr,
      output rom_valid, rom_data,
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_dat_o, wbs_ack_o,
      output sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
      input  sram_dout
   );

   modport master (
      output rom_req, rom_addr,
      input  rom_valid, rom_data,
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_dat_o, wbs_ack_o,
      input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
      output sram_dout
   );
endinterface

// File: rtl/oram_fetch_arbiter.sv
// Shares one 1RW SRAM between a buffered byte-wide core fetch port and a Wishbone loader.
// Latency: core hit 1, miss 3, WB write 2, WB read/out-of-window 2-3. WB waits at most STARVE_MAX core SRAM grants.
module oram_fetch_arbiter #(
   parameter int ADDR_W     = 9,
   parameter int STARVE_MAX = 4,
   parameter int WB_SEL_BIT = 16
) (
   input logic                 wb_clk_i,
   input logic                 wb_rst_ni,
   oram_fetch_arbiter_if.slave bus
);
   localparam int CW = $clog2(STARVE_MAX + 1);

   typedef enum logic [2:0] {
      IDLE, CORE_RD, CORE_CAP, WB_WR, WB_RD, WB_CAP, WB_ACK
   } state_t;

   state_t            r_state;
   logic              r_buf_valid;
   logic [ADDR_W-1:0] r_buf_addr;
   logic [31:0]       r_buf_data;
   logic [CW-1:0]     r_starve;
   logic [1:0]        r_core_lane;
   logic              r_wb_oow;
   logic              r_rom_valid;
   logic [7:0]        r_rom_data;
   logic [31:0]       r_dat_o;
   logic              r_ack;
   logic              r_csb;
   logic              r_web;
   logic [3:0]        r_wmask;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_din;

   logic              w_wb_req;
   logic              w_win;
   logic [ADDR_W-1:0] w_rom_word;
   logic [ADDR_W-1:0] w_wb_word;
   logic              w_match;
   logic              w_hit;
   logic              w_miss;
   logic              w_starved;
   logic              w_unused;

   assign w_wb_req   = bus.wbs_cyc_i & bus.wbs_stb_i & ~r_ack;
   assign w_win      = bus.wbs_adr_i[WB_SEL_BIT];
   assign w_rom_word = bus.rom_addr[ADDR_W+1:2];
   assign w_wb_word  = bus.wbs_adr_i[ADDR_W+1:2];
   assign w_match    = r_buf_valid & (r_buf_addr == w_rom_word);
   // A request still held in its own rom_valid cycle must not be served twice.
   assign w_hit      = bus.rom_req & w_match & ~r_rom_valid;
   assign w_miss     = bus.rom_req & ~w_match;
   assign w_starved  = (r_starve == CW'(STARVE_MAX));
   assign w_unused   = &{1'b0, bus.wbs_adr_i, 1'b0};

   assign bus.rom_valid  = r_rom_valid;
   assign bus.rom_data   = r_rom_data;
   assign bus.wbs_dat_o  = r_dat_o;
   assign bus.wbs_ack_o  = r_ack;
   assign bus.sram_csb   = r_csb;
   assign bus.sram_web   = r_web;
   assign bus.sram_wmask = r_wmask;
   assign bus.sram_addr  = r_addr;
   assign bus.sram_din   = r_din;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state     <= IDLE;
         r_buf_valid <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_data  <= '0;
         r_starve    <= '0;
         r_core_lane <= '0;
         r_wb_oow    <= 1'b0;
         r_rom_valid <= 1'b0;
         r_rom_data  <= '0;
         r_dat_o     <= '0;
         r_ack       <= 1'b0;
         r_csb       <= 1'b1;
         r_web       <= 1'b1;
         r_wmask     <= '0;
         r_addr      <= '0;
         r_din       <= '0;
      end else begin
         r_rom_valid <= 1'b0;
         r_ack       <= 1'b0;
         r_csb       <= 1'b1;
         r_web       <= 1'b1;
         r_wmask     <= '0;
         case (r_state)
            IDLE: begin
               if (w_hit) begin
                  r_rom_valid <= 1'b1;
                  r_rom_data  <= r_buf_data[{bus.rom_addr[1:0], 3'b000} +: 8];
               end
               if (w_wb_req && !w_win) begin
                  // Out-of-window accesses skip the SRAM and return zero.
                  r_wb_oow <= 1'b1;
                  r_state  <= WB_CAP;
               end else if (w_wb_req && (!w_miss || w_starved)) begin
                  r_wb_oow <= 1'b0;
                  r_starve <= '0;
                  r_csb    <= 1'b0;
                  r_addr   <= w_wb_word;
                  if (bus.wbs_we_i) begin
                     r_web   <= 1'b0;
                     r_wmask <= bus.wbs_sel_i;
                     r_din   <= bus.wbs_dat_i;
                     r_state <= WB_WR;
                  end else begin
                     r_state <= WB_RD;
                  end
               end else if (w_miss) begin
                  r_csb       <= 1'b0;
                  r_addr      <= w_rom_word;
                  r_core_lane <= bus.rom_addr[1:0];
                  r_state     <= CORE_RD;
                  if (w_wb_req && !w_starved) r_starve <= r_starve + CW'(1);
               end
            end
            CORE_RD: r_state <= CORE_CAP;
            CORE_CAP: begin
               r_buf_data  <= bus.sram_dout;
               r_buf_addr  <= r_addr;
               r_buf_valid <= 1'b1;
               r_rom_valid <= 1'b1;
               r_rom_data  <= bus.sram_dout[{r_core_lane, 3'b000} +: 8];
               r_state     <= IDLE;
            end
            WB_WR: begin
               if (r_addr == r_buf_addr) r_buf_valid <= 1'b0;
               r_ack   <= 1'b1;
               r_state <= WB_ACK;
            end
            WB_RD: r_state <= WB_CAP;
            WB_CAP: begin
               r_dat_o <= r_wb_oow ? 32'h0 : bus.sram_dout;
               r_ack   <= 1'b1;
               r_state <= WB_ACK;
            end
            WB_ACK:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_oram_fetch_arbiter.sv
// Directed bench for oram_fetch_arbiter with a behavioural 1RW SRAM model.
module tb_oram_fetch_arbiter;
   logic clk;
   logic rst_n;
   int   n_run    = 0;
   int   n_fail   = 0;
   int   rv_cnt   = 0;
   int   ack_cnt  = 0;
   int   csb_lows = 0;
   logic [31:0] mem [0:511];

   oram_fetch_arbiter_if #(.ADDR_W(9)) bus ();

   oram_fetch_arbiter #(.ADDR_W(9), .STARVE_MAX(4), .WB_SEL_BIT(16)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .bus       (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] k;
      k = 8'(i - 16);
      if (i == 5)  return 32'hDDCCBBAA;
      if (i == 6)  return 32'h44332211;
      if (i == 10) return 32'hCAFEF00D;
      if (i >= 16 && i <= 21) return {8'h10 + k, 8'h20 + k, 8'h30 + k, 8'hA0 + k};
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      end else if (!bus.sram_csb) begin
         if (!bus.sram_web) begin
            for (int b = 0; b < 4; b++)
               if (bus.sram_wmask[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_din[8*b +: 8];
         end else begin
            bus.sram_dout <= mem[bus.sram_addr];
         end
      end
   end

   always @(negedge clk) begin
      if (bus.rom_valid === 1'b1) rv_cnt++;
      if (bus.wbs_ack_o === 1'b1) ack_cnt++;
      if (bus.sram_csb === 1'b0) csb_lows++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rom(output int lat, output logic [7:0] d);
      lat = -1;
      d   = 8'h0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (bus.rom_valid === 1'b1) begin
            lat = i;
            d   = bus.rom_data;
            break;
         end
      end
      bus.rom_req = 1'b0;
   endtask

   task automatic wait_ack(output int lat, output logic [31:0] d);
      lat = -1;
      d   = 32'h0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (bus.wbs_ack_o === 1'b1) begin
            lat = i;
            d   = bus.wbs_dat_o;
            break;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
   endtask

   task automatic wb_start(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_sel_i = sel;
      bus.wbs_dat_i = dat;
   endtask

   initial begin
      int          lat;
      logic [7:0]  d;
      logic [31:0] w;
      int          snap_rv, snap_ack, snap_csb;
      int          core_done, t4, ta, grants_at_ack;
      logic        ack_seen;

      rst_n         = 1'b0;
      bus.rom_req   = 1'b0;
      bus.rom_addr  = '0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_csb",      32'(bus.sram_csb),   32'h1);
      check("rst_web",      32'(bus.sram_web),   32'h1);
      check("rst_wmask",    32'(bus.sram_wmask), 32'h0);
      check("rst_addr",     32'(bus.sram_addr),  32'h0);
      check("rst_din",      bus.sram_din,        32'h0);
      check("rst_dat_o",    bus.wbs_dat_o,       32'h0);
      check("rst_ack",      32'(bus.wbs_ack_o),  32'h0);
      check("rst_rom_vld",  32'(bus.rom_valid),  32'h0);
      check("rst_rom_data", 32'(bus.rom_data),   32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_csb", 32'(bus.sram_csb), 32'h1);

      // Core miss on word 5, then hit on the buffered word
      bus.rom_req = 1'b1; bus.rom_addr = 11'h015;
      wait_rom(lat, d);
      check("miss_lat",  32'(lat), 32'd3);
      check("miss_data", 32'(d),   32'hBB);
      @(posedge clk); #1;
      snap_csb = csb_lows;
      bus.rom_req = 1'b1; bus.rom_addr = 11'h017;
      wait_rom(lat, d);
      check("hit_lat",  32'(lat), 32'd1);
      check("hit_data", 32'(d),   32'hDD);
      @(posedge clk); #1;
      check("hit_no_sram", 32'(csb_lows - snap_csb), 32'd0);

      // WB byte write to word 5 invalidates the buffer
      wb_start(1'b1, 32'h0001_0014, 4'b0010, 32'h0000_EE00);
      wait_ack(lat, w);
      check("wbwr_lat", 32'(lat), 32'd2);
      @(posedge clk); #1;
      bus.rom_req = 1'b1; bus.rom_addr = 11'h015;
      wait_rom(lat, d);
      check("inval_lat",  32'(lat), 32'd3);
      check("inval_data", 32'(d),   32'hEE);
      @(posedge clk); #1;

      // In-window WB read, then out-of-window read
      wb_start(1'b0, 32'h0001_0018, 4'hF, 32'h0);
      wait_ack(lat, w);
      check("wbrd_lat",  32'(lat), 32'd3);
      check("wbrd_data", w,        32'h44332211);
      @(posedge clk); #1;
      snap_csb = csb_lows;
      wb_start(1'b0, 32'h0000_0020, 4'hF, 32'h0);
      wait_ack(lat, w);
      check("oow_lat",  32'(lat), 32'd2);
      check("oow_data", w,        32'h0);
      @(posedge clk); #1;
      check("oow_no_sram", 32'(csb_lows - snap_csb), 32'd0);

      // Starvation: continuous core misses on words 16.. while a WB read of word 10 waits
      core_done = 0; t4 = -1; ta = -1; grants_at_ack = -1; ack_seen = 1'b0; w = 32'h0;
      wb_start(1'b0, 32'h0001_0028, 4'hF, 32'h0);
      bus.rom_req = 1'b1; bus.rom_addr = 11'h040;
      for (int c = 1; c <= 200 && !(ack_seen && core_done >= 5); c++) begin
         @(posedge clk); #1;
         if (bus.rom_valid === 1'b1) begin
            check($sformatf("starve_core%0d", core_done), 32'(bus.rom_data), 32'h0A0 + 32'(core_done));
            core_done++;
            if (core_done == 4) t4 = c;
            if (core_done >= 5) bus.rom_req = 1'b0;
            else bus.rom_addr = 11'((16 + core_done) * 4);
         end
         if (bus.wbs_ack_o === 1'b1) begin
            ack_seen = 1'b1; ta = c; grants_at_ack = core_done; w = bus.wbs_dat_o;
            bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
         end
      end
      bus.rom_req = 1'b0;
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      check("starve_grants",    32'(grants_at_ack), 32'd4);
      check("starve_ack_delay", 32'(ta - t4),       32'd3);
      check("starve_rdata",     w,                  32'hCAFEF00D);
      check("starve_core_done", 32'(core_done),     32'd5);
      @(posedge clk); #1;

      // Simultaneous hit on buffered word 20 and out-of-window WB write
      snap_rv = rv_cnt; snap_ack = ack_cnt; snap_csb = csb_lows;
      d = 8'h0; w = 32'hFFFF_FFFF;
      bus.rom_req = 1'b1; bus.rom_addr = 11'h051;
      wb_start(1'b1, 32'h0000_0024, 4'hF, 32'h1234_5678);
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (bus.rom_valid === 1'b1) begin d = bus.rom_data; bus.rom_req = 1'b0; end
         if (bus.wbs_ack_o === 1'b1) begin
            w = bus.wbs_dat_o; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
         end
      end
      bus.rom_req = 1'b0;
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      @(posedge clk); #1;
      check("sim_rv_once",  32'(rv_cnt - snap_rv),     32'd1);
      check("sim_ack_once", 32'(ack_cnt - snap_ack),   32'd1);
      check("sim_no_sram",  32'(csb_lows - snap_csb),  32'd0);
      check("sim_rom_data", 32'(d),                    32'h34);
      check("sim_dat_o",    w,                         32'h0);

      // Reset asserted mid CORE_RD abandons the fetch and clears the buffer
      bus.rom_req = 1'b1; bus.rom_addr = 11'h018;
      @(posedge clk); #1;
      check("pre_rst_csb", 32'(bus.sram_csb), 32'h0);
      snap_rv = rv_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_csb", 32'(bus.sram_csb),  32'h1);
      check("midrst_web", 32'(bus.sram_web),  32'h1);
      check("midrst_rv",  32'(bus.rom_valid), 32'h0);
      check("midrst_ack", 32'(bus.wbs_ack_o), 32'h0);
      repeat (2) @(posedge clk);
      bus.rom_req = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_no_valid", 32'(rv_cnt - snap_rv), 32'd0);
      check("postrst_addr",    32'(bus.sram_addr),    32'h0);
      bus.rom_req = 1'b1; bus.rom_addr = 11'h051;
      wait_rom(lat, d);
      check("postrst_miss_lat",  32'(lat), 32'd3);
      check("postrst_miss_data", 32'(d),   32'h34);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
